crack_sched: RTL and testbench

Scheduler that splits the 24-bit key search across NUM_CORES crack cores and launches each core through the ready-enable protocol. It collects the first valid key found, cancels the remaining cores, and reports one result upward. It sits between the top-level mailbox/competition FSM and the array of crack cores that share the ciphertext memory.

---
 rtl/crack_sched_if.sv | 30 +++
 rtl/crack_sched.sv | 138 +++++++++++++
 tb/tb_crack_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/crack_sched_if.sv
// Handshake bundle between crack_sched, the mailbox FSM above it and the crack cores below it.
interface crack_sched_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24
);
  logic                       en;
  logic                       rdy;
  logic                       key_valid;
  logic [KEY_W-1:0]           key;
  logic [NUM_CORES-1:0]       core_en;
  logic [NUM_CORES-1:0]       core_rdy;
  logic                       core_cancel;
  logic [NUM_CORES*KEY_W-1:0] core_start;
  logic [7:0]                 core_stride;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_key_valid;
  logic [NUM_CORES*KEY_W-1:0] core_key;

  // Scheduler side
  modport master (
    input  en, core_rdy, core_done, core_key_valid, core_key,
    output rdy, key_valid, key, core_en, core_cancel, core_start, core_stride
  );

  // Mailbox FSM and core array side
  modport slave (
    output en, core_rdy, core_done, core_key_valid, core_key,
    input  rdy, key_valid, key, core_en, core_cancel, core_start, core_stride
  );
endinterface

// File: rtl/crack_sched.sv
// Splits the key search across NUM_CORES crack cores, keeps the first valid key, cancels the rest.
// Optional cycle counter output enabled by defining CRACK_SCHED_CYCLE_COUNT_EN.
module crack_sched #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  crack_sched_if.master     bus
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
  ,
  output logic [31:0]       cycles
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    CANCEL = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [NUM_CORES-1:0] done_mask;
  logic [NUM_CORES-1:0] done_seen;
  logic [NUM_CORES-1:0] launched;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] core_en_c;
  logic [KEY_W-1:0]     win_key;
  logic [KEY_W-1:0]     key_r;
  logic                 key_valid_r;
  logic                 launch_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    core_en_c   = '0;
    launch_fire = 1'b0;
    case (state)
      IDLE:   if (bus.en) state_nxt = LAUNCH;
      LAUNCH: begin
        if (bus.core_rdy[idx]) begin
          core_en_c[idx] = 1'b1;
          launch_fire    = 1'b1;
          if (idx == IDX_W'(NUM_CORES - 1)) state_nxt = RUN;
        end
      end
      RUN: begin
        if (|hit)            state_nxt = CANCEL;
        else if (&done_seen) state_nxt = IDLE;
      end
      CANCEL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner is the lowest-index core reporting a valid key this cycle; a done
  // flag left over from the previous search only counts once its core is relaunched.
  always_comb begin
    done_seen = done_mask | bus.core_done;
    hit       = bus.core_done & bus.core_key_valid;
    win_key   = '0;
    launched  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) win_key = bus.core_key[i*KEY_W +: KEY_W];
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      launched[i] = (i < int'(idx));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      done_mask   <= '0;
      key_r       <= '0;
      key_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            idx         <= '0;
            done_mask   <= '0;
            key_r       <= '0;
            key_valid_r <= 1'b0;
          end
        end
        LAUNCH: begin
          done_mask <= done_mask | (bus.core_done & launched);
          if (launch_fire) idx <= idx + IDX_W'(1);
        end
        RUN: begin
          done_mask <= done_seen;
          if (|hit) begin
            key_r       <= win_key;
            key_valid_r <= 1'b1;
          end else if (&done_seen) begin
            key_r       <= '0;
            key_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CRACK_SCHED_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else if (state == IDLE) begin
      if (bus.en) cycles <= '0;
    end else if (cycles != 32'hFFFF_FFFF) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

  assign bus.rdy         = (state == IDLE);
  assign bus.key_valid   = key_valid_r;
  assign bus.key         = key_r;
  assign bus.core_en     = core_en_c;
  assign bus.core_cancel = (state == CANCEL);
  assign bus.core_stride = 8'(NUM_CORES);

  // Core i starts at key i and steps by NUM_CORES, interleaving the key space.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_start
    assign bus.core_start[g*KEY_W +: KEY_W] = KEY_W'(g);
  end

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched: per-cycle vector table plus hand-written stall, timeout and reset sequences.
module tb_crack_sched;
  localparam int NC = 2;
  localparam int KW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  crack_sched_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
  logic [31:0] cycles;
`endif

  crack_sched #(.NUM_CORES(NC), .KEY_W(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    ,
    .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic e, input logic [1:0] r, input logic [1:0] d,
                       input logic [1:0] v, input logic [23:0] k0, input logic [23:0] k1);
    @(negedge clk);
    bus.en             = e;
    bus.core_rdy       = r;
    bus.core_done      = d;
    bus.core_key_valid = v;
    bus.core_key       = {k1, k0};
    #1;
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  crdy;
    logic [1:0]  cdone;
    logic [1:0]  cval;
    logic [23:0] k0;
    logic [23:0] k1;
    logic        e_rdy;
    logic [1:0]  e_cen;
    logic        e_cancel;
    logic        e_kv;
    logic [23:0] e_key;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [23:0] slice;
    logic [1:0]  d;

    bus.en = 1'b0; bus.core_rdy = '0; bus.core_done = '0;
    bus.core_key_valid = '0; bus.core_key = '0;

    // ---------------- reset and idle ----------------
    #1;
    chk("rst.rdy", 32'(bus.rdy), 32'd1);
    chk("rst.key_valid", 32'(bus.key_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(1'b0, 2'b00, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("idle.rdy", 32'(bus.rdy), 32'd1);
    chk("idle.key_valid", 32'(bus.key_valid), 32'd0);
    chk("idle.key", 32'(bus.key), 32'd0);
    chk("idle.core_en", 32'(bus.core_en), 32'd0);
    chk("idle.core_cancel", 32'(bus.core_cancel), 32'd0);
    slice = bus.core_start[KW +: KW];
    chk("idle.core_start1", 32'(slice), 32'h000001);
    slice = bus.core_start[0 +: KW];
    chk("idle.core_start0", 32'(slice), 32'h000000);
    chk("idle.core_stride", 32'(bus.core_stride), 32'd2);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    chk("idle.cycles", cycles, 32'd0);
`endif

    // ---------------- vector table ----------------
    // single winner on core 1
    vecs.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b01, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b10, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b00, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b10, 2'b10, 24'h0, 24'h1E4600, 1'b0, 2'b00, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b10, 2'b10, 24'h0, 24'h1E4600, 1'b0, 2'b00, 1'b1, 1'b1, 24'h1E4600});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b1, 24'h1E4600});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b1, 24'h1E4600});
    // simultaneous winners, lowest index kept; en during LAUNCH ignored
    vecs.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b1, 24'h1E4600});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b01, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b10, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b11, 2'b11, 24'h10, 24'h11,    1'b0, 2'b00, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b11, 2'b11, 24'h10, 24'h11,    1'b0, 2'b00, 1'b1, 1'b1, 24'h10});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b1, 24'h10});
    // core 0 finishes during LAUNCH, core 1 later, no key found
    vecs.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b1, 24'h10});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b01, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b01, 2'b00, 24'h0, 24'h0,      1'b0, 2'b10, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b0, 2'b00, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b10, 2'b00, 24'h0, 24'h0,      1'b0, 2'b00, 1'b0, 1'b0, 24'h0});
    vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0,      1'b1, 2'b00, 1'b0, 1'b0, 24'h0});

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].crdy, vecs[i].cdone, vecs[i].cval, vecs[i].k0, vecs[i].k1);
      chk($sformatf("vec%0d.rdy", i), 32'(bus.rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.core_en", i), 32'(bus.core_en), 32'(vecs[i].e_cen));
      chk($sformatf("vec%0d.core_cancel", i), 32'(bus.core_cancel), 32'(vecs[i].e_cancel));
      chk($sformatf("vec%0d.key_valid", i), 32'(bus.key_valid), 32'(vecs[i].e_kv));
      chk($sformatf("vec%0d.key", i), 32'(bus.key), 32'(vecs[i].e_key));
    end

    // ---------------- core 1 not ready for 10 cycles ----------------
    drive(1'b1, 2'b01, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("stall.accept_rdy", 32'(bus.rdy), 32'd1);
    drive(1'b0, 2'b01, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("stall.core_en0", 32'(bus.core_en), 32'b01);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b01, 2'b00, 2'b00, 24'h0, 24'h0);
      if (bus.core_en !== 2'b00 || bus.rdy !== 1'b0) bad++;
    end
    chk("stall.quiet_cycles", 32'(bad), 32'd0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("stall.core_en1", 32'(bus.core_en), 32'b10);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("stall.run_core_en", 32'(bus.core_en), 32'b00);
    drive(1'b0, 2'b11, 2'b10, 2'b10, 24'h0, 24'h0ABCDE);
    drive(1'b0, 2'b11, 2'b10, 2'b10, 24'h0, 24'h0ABCDE);
    chk("stall.cancel", 32'(bus.core_cancel), 32'd1);
    chk("stall.key", 32'(bus.key), 32'h0ABCDE);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("stall.rdy", 32'(bus.rdy), 32'd1);

    // ---------------- no key: done at RUN cycles 100 and 200 ----------------
    drive(1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    bad = 0;
    for (int c = 1; c <= 200; c++) begin
      d = (c >= 200) ? 2'b11 : ((c >= 100) ? 2'b01 : 2'b00);
      drive(1'b0, 2'b11, d, 2'b00, 24'h0, 24'h0);
      if (bus.rdy !== 1'b0 || bus.core_cancel !== 1'b0) bad++;
    end
    chk("nokey.busy_window", 32'(bad), 32'd0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("nokey.rdy", 32'(bus.rdy), 32'd1);
    chk("nokey.cancel", 32'(bus.core_cancel), 32'd0);
    chk("nokey.key_valid", 32'(bus.key_valid), 32'd0);
    chk("nokey.key", 32'(bus.key), 32'd0);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    chk("nokey.cycles", cycles, 32'd202);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("nokey.cycles_hold", cycles, 32'd202);
`endif

    // ---------------- asynchronous reset during RUN ----------------
    drive(1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("midrst.pre_rdy", 32'(bus.rdy), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.rdy", 32'(bus.rdy), 32'd1);
    chk("midrst.core_en", 32'(bus.core_en), 32'd0);
    chk("midrst.cancel", 32'(bus.core_cancel), 32'd0);
    chk("midrst.key_valid", 32'(bus.key_valid), 32'd0);
    chk("midrst.key", 32'(bus.key), 32'd0);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    chk("midrst.cycles", cycles, 32'd0);
`endif
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("midrst.no_cancel", 32'(bus.core_cancel), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("relaunch.rdy", 32'(bus.rdy), 32'd1);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("relaunch.core_en0", 32'(bus.core_en), 32'b01);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    chk("relaunch.cycles0", cycles, 32'd0);
`endif
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("relaunch.core_en1", 32'(bus.core_en), 32'b10);
    drive(1'b0, 2'b11, 2'b01, 2'b01, 24'h000005, 24'h0);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    chk("relaunch.cycles_run", cycles, 32'd2);
`endif
    drive(1'b0, 2'b11, 2'b01, 2'b01, 24'h000005, 24'h0);
    chk("relaunch.cancel", 32'(bus.core_cancel), 32'd1);
    chk("relaunch.key", 32'(bus.key), 32'h000005);
    chk("relaunch.key_valid", 32'(bus.key_valid), 32'd1);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 24'h0, 24'h0);
    chk("relaunch.rdy_end", 32'(bus.rdy), 32'd1);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    chk("relaunch.cycles_end", cycles, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
